// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Purpose  : Program counter and fetch sequencer in front of a 1-cycle
//             registered instruction RAM. Captures each word into an
//             instruction register, presents opcode/operand to the control
//             unit and resolves JUMPZ/JUMPNZ locally on the ack edge.
//  Config   : IFU_NOP_HALT_EN - when defined, acking a NOP halts the
//             sequencer cleanly (err=0) instead of stepping to pc+1.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
   parameter int ADDR_W     = 9,
   parameter int INSTR_W    = 16,
   parameter int OP_W       = 6,
   parameter int PROG_DEPTH = 166,
   parameter int START_ADDR = 0,
   parameter int OP_NOP     = 46,
   parameter int OP_JUMPNZ  = 47,
   parameter int OP_JUMPZ   = 52
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [INSTR_W-1:0]      imem_data,
   input  logic                    instr_ack,
   input  logic                    z_flag,
   output logic [ADDR_W-1:0]       imem_addr,
   output logic [OP_W-1:0]         opcode,
   output logic [INSTR_W-OP_W-1:0] operand,
   output logic                    instr_valid,
   output logic                    halted,
   output logic                    err
);

   localparam int OPD_W = INSTR_W - OP_W;
   // One bit wider than the larger of pc / operand so pc+1 and the raw
   // operand are both range-checked before any truncation to ADDR_W.
   localparam int NXT_W = ((ADDR_W > OPD_W) ? ADDR_W : OPD_W) + 1;

`ifdef IFU_NOP_HALT_EN
   localparam logic C_NOP_HALT_EN = 1'b1;
`else
   localparam logic C_NOP_HALT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_CAPT  = 3'd2,
      S_HOLD  = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   w_pc_nxt;
   logic [INSTR_W-1:0]  r_ir;
   logic [INSTR_W-1:0]  w_ir_nxt;
   logic                r_err;
   logic                w_err_nxt;

   logic [OP_W-1:0]     w_op;
   logic [OPD_W-1:0]    w_opd;
   logic                w_take;
   logic                w_nop_halt;
   logic [NXT_W-1:0]    w_next;
   logic                w_oob;

   assign w_op  = r_ir[INSTR_W-1 -: OP_W];
   assign w_opd = r_ir[OPD_W-1:0];

   // Branch resolution uses the z_flag value present on the ack edge.
   assign w_take = ((w_op == OP_W'(OP_JUMPZ))  &&  z_flag) ||
                   ((w_op == OP_W'(OP_JUMPNZ)) && !z_flag);

   assign w_nop_halt = C_NOP_HALT_EN && (w_op == OP_W'(OP_NOP));

   assign w_next = w_take ? NXT_W'(w_opd) : (NXT_W'(r_pc) + NXT_W'(1));
   assign w_oob  = (w_next >= NXT_W'(PROG_DEPTH));

   assign imem_addr   = r_pc;
   assign opcode      = w_op;
   assign operand     = w_opd;
   assign instr_valid = (r_state == S_HOLD);
   assign halted      = (r_state == S_HALT);
   assign err         = r_err;

   // State, program counter, instruction register and error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pc    <= ADDR_W'(START_ADDR);
         r_ir    <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_ir    <= w_ir_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Fetch sequencing and next-pc selection.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_ir_nxt    = r_ir;
      w_err_nxt   = r_err;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_pc_nxt    = ADDR_W'(START_ADDR);
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // RAM registers mem[pc] on this edge.
            w_state_nxt = S_CAPT;
         end
         S_CAPT: begin
            w_ir_nxt    = imem_data;
            w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (instr_ack) begin
               if (w_nop_halt) begin
                  w_err_nxt   = 1'b0;
                  w_state_nxt = S_HALT;
               end else if (w_oob) begin
                  // pc is left pointing at the offending instruction.
                  w_err_nxt   = 1'b1;
                  w_state_nxt = S_HALT;
               end else begin
                  w_pc_nxt    = w_next[ADDR_W-1:0];
                  w_state_nxt = S_ISSUE;
               end
            end
         end
         S_HALT: begin
            if (start) begin
               w_err_nxt   = 1'b0;
               w_pc_nxt    = ADDR_W'(START_ADDR);
               w_state_nxt = S_ISSUE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Purpose  : Scoreboard bench for instr_fetch_unit. A program-level model
//             pushes expected fetches/halts; a monitor pops and compares.
//  Config   : IFU_NOP_HALT_EN selects the NOP-halts model behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

   localparam int PD = 166;
`ifdef IFU_NOP_HALT_EN
   localparam bit NOP_HALT = 1'b1;
`else
   localparam bit NOP_HALT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        instr_ack = 1'b0;
   logic        z_flag = 1'b0;
   logic [15:0] imem_data;
   logic [8:0]  imem_addr;
   logic [5:0]  opcode;
   logic [9:0]  operand;
   logic        instr_valid;
   logic        halted;
   logic        err;

   logic [15:0] mem [0:511];

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct { int addr; int word; } fetch_t;
   typedef struct { int addr; int e;    } halt_t;
   fetch_t fetch_q[$];
   halt_t  halt_q[$];

   int m_pc;
   bit m_halted;

   always #5 clk = ~clk;

   // Instruction RAM: one-cycle registered read.
   always @(posedge clk) imem_data <= mem[imem_addr];

   instr_fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .imem_data   (imem_data),
      .instr_ack   (instr_ack),
      .z_flag      (z_flag),
      .imem_addr   (imem_addr),
      .opcode      (opcode),
      .operand     (operand),
      .instr_valid (instr_valid),
      .halted      (halted),
      .err         (err)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Program-level model: executes one acked instruction.
   task automatic model_ack(input bit z, output bit hlt);
      int word, op, opd, nxt;
      bit take;
      word = int'(mem[m_pc]);
      op   = word / 1024;
      opd  = word % 1024;
      take = (op == 52 && z) || (op == 47 && !z);
      nxt  = take ? opd : m_pc + 1;
      hlt  = 1'b0;
      if (NOP_HALT && op == 46) begin
         halt_q.push_back('{addr: m_pc, e: 0});
         hlt = 1'b1;
      end else if (nxt >= PD) begin
         halt_q.push_back('{addr: m_pc, e: 1});
         hlt = 1'b1;
      end else begin
         m_pc = nxt;
         fetch_q.push_back('{addr: m_pc, word: int'(mem[m_pc])});
      end
      m_halted = hlt;
   endtask

   task automatic model_start();
      m_pc     = 0;
      m_halted = 1'b0;
      fetch_q.push_back('{addr: 0, word: int'(mem[0])});
   endtask

   // Monitor: compare every newly presented instruction and every halt entry.
   logic prev_v = 1'b0;
   logic prev_h = 1'b0;
   always @(negedge clk) begin
      if (instr_valid && !prev_v) begin
         if (fetch_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_fetch: got addr %0d expected no fetch", imem_addr);
         end else begin
            fetch_t e;
            e = fetch_q.pop_front();
            chk("fetch_addr", imem_addr, e.addr);
            chk("opcode", opcode, e.word / 1024);
            chk("operand", operand, e.word % 1024);
         end
      end
      if (halted && !prev_h) begin
         if (halt_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_halt: got halted at addr %0d expected none", imem_addr);
         end else begin
            halt_t h;
            h = halt_q.pop_front();
            chk("halt_addr", imem_addr, h.addr);
            chk("halt_err", err, h.e);
            chk("halt_valid_low", instr_valid, 0);
         end
      end
      prev_v <= instr_valid;
      prev_h <= halted;
   end

   // Wait for HOLD or HALT; edges already elapsed passed in, total returned.
   task automatic wait_ready(inout int edges);
      while (!(instr_valid || halted) && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic do_start();
      int edges;
      @(negedge clk);
      start = 1'b1;
      model_start();
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("start_halted_clr", halted, 0);
      chk("start_err_clr", err, 0);
      chk("start_addr", imem_addr, 0);
      chk("start_valid_low", instr_valid, 0);
      edges = 1;
      wait_ready(edges);
      chk("start_latency", edges, 3);
   endtask

   // Optional HOLD dwell with ignored start pulses, then ack with given z.
   task automatic step(input bit z);
      int edges;
      bit hlt;
      int dwell;
      dwell = $urandom_range(0, 3);
      repeat (dwell) begin
         @(negedge clk);
         start = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      start     = 1'b0;
      instr_ack = 1'b1;
      z_flag    = z;
      model_ack(z, hlt);
      @(posedge clk);
      #1;
      instr_ack = 1'b0;
      z_flag    = 1'($urandom_range(0, 1));
      chk("valid_drop", instr_valid, 0);
      edges = 1;
      wait_ready(edges);
      if (hlt) chk("halt_latency", edges, 1);
      else     chk("fetch_latency", edges, 3);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int v142, v163, adv, guard;
      bit z, hlt;

      for (int i = 0; i < 512; i++) mem[i] = {6'd0, 10'($urandom)};
      mem[142] = {6'd52, 10'd159};
      mem[163] = {6'd47, 10'd63};
      mem[164] = {6'd46, 10'd0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_addr", imem_addr, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_err", err, 0);
      chk("rst_opcode", opcode, 0);
      chk("rst_operand", operand, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("idle_no_fetch", instr_valid, 0);

      // Sequential run with directed branch outcomes until halt
      do_start();
      v142 = 0;
      v163 = 0;
      guard = 0;
      while (!m_halted && guard < 400) begin
         if (m_pc == 142) begin z = (v142 == 0); v142++; end
         else if (m_pc == 163) begin z = (v163 != 0); v163++; end
         else z = 1'($urandom_range(0, 1));
         step(z);
         guard++;
      end
      chk("prog1_halted", halted, 1);
      chk("prog1_err", err, NOP_HALT ? 0 : 1);
      chk("prog1_addr", imem_addr, NOP_HALT ? 164 : 165);

      // Out-of-range jump target
      mem[5] = {6'd52, 10'd600};
      do_start();
      repeat (5) step(1'b0);
      step(1'b1);
      chk("oob_halted", halted, 1);
      chk("oob_err", err, 1);
      chk("oob_addr", imem_addr, 5);
      do_start();

      // Asynchronous reset while in HOLD
      step(1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", instr_valid, 0);
      chk("arst_addr", imem_addr, 0);
      chk("arst_halted", halted, 0);
      chk("arst_err", err, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("arst_no_fetch", instr_valid, 0);
      chk("arst_q_empty", fetch_q.size(), 0);
      do_start();

      // Ack held high for 10 cycles from HOLD at pc 0
      adv = 0;
      @(negedge clk);
      instr_ack = 1'b1;
      z_flag    = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         if (instr_valid) begin
            model_ack(1'b0, hlt);
            adv++;
         end
         @(posedge clk);
      end
      #1;
      instr_ack = 1'b0;
      chk("held_ack_advances", adv, 4);
      begin
         int edges;
         edges = 0;
         wait_ready(edges);
      end
      chk("held_ack_pc", imem_addr, 4);

      // Randomised programs
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < PD; i++) begin
         int r, op;
         r = $urandom_range(0, 99);
         if (r < 40)      op = 0;
         else if (r < 55) op = 52;
         else if (r < 70) op = 47;
         else if (r < 80) op = 46;
         else             op = $urandom_range(0, 63);
         mem[i] = {6'(op), 10'($urandom_range(0, 199))};
      end
      do_start();
      for (int i = 0; i < 300; i++) begin
         if (m_halted) do_start();
         else step(1'($urandom_range(0, 1)));
      end

      repeat (5) @(posedge clk);
      #1;
      chk("fetch_q_drained", fetch_q.size(), 0);
      chk("halt_q_drained", halt_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
